// File: rtl/random_draw.sv
// random_draw: uniform integers in [0, bound) by rejection sampling over WIDTH-bit chunks of a snapshotted random word
module random_draw #(
    parameter int WIDTH     = 8,
    parameter int MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [255:0]     rand_word,
    input  logic             req,
    input  logic [WIDTH-1:0] bound,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] value,
    output logic             err
);
    localparam int NCHUNK = 256 / WIDTH;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam int TW = $clog2(MAX_TRIES + 1);
    typedef enum logic {IDLE, SAMPLE} state_t;
    state_t           state;
    logic [255:0]     buffer;
    logic [IW-1:0]    idx;
    logic [TW-1:0]    tries;
    logic [WIDTH-1:0] lbound, mask, mask_n, cand;
    // smear the top set bit of bound-1 downwards to get the smallest 2^k-1 covering it
    always_comb begin
        mask_n = bound - WIDTH'(1);
        for (int s = 1; s < WIDTH; s = s * 2) mask_n = mask_n | (mask_n >> s);
    end
    assign cand = buffer[WIDTH*idx +: WIDTH] & mask;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            valid  <= 1'b0;
            err    <= 1'b0;
            value  <= '0;
            buffer <= '0;
            idx    <= '0;
            tries  <= '0;
            lbound <= '0;
            mask   <= '0;
        end else begin
            valid <= 1'b0;
            err   <= 1'b0;
            if (state == IDLE) begin
                if (req && bound == '0) begin
                    err <= 1'b1;
                end else if (req) begin
                    lbound <= bound;
                    mask   <= mask_n;
                    buffer <= rand_word;
                    idx    <= '0;
                    tries  <= '0;
                    state  <= SAMPLE;
                    busy   <= 1'b1;
                end
            end else if (cand < lbound || tries == TW'(MAX_TRIES - 1)) begin
                // mask < 2*bound, so a rejected candidate minus bound is always in range
                value <= cand < lbound ? cand : cand - lbound;
                valid <= 1'b1;
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                tries <= tries + TW'(1);
                if (idx == IW'(NCHUNK - 1)) begin
                    idx    <= '0;
                    buffer <= rand_word;
                end else begin
                    idx <= idx + IW'(1);
                end
            end
        end
    end
endmodule
